// File: rtl/mem_stage_bridge.sv
// rtl/mem_stage_bridge.sv - MEM-stage data port to single-ported variable-latency memory bus bridge
// Big-endian lanes; one outstanding word transaction; pipeline held while it is in flight.
module mem_stage_bridge #(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 12,
  parameter int TimeoutCycles = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           core_read_i,
  input  logic [1:0]           core_write_i,
  input  logic                 core_unsigned_i,
  input  logic [DataWidth-1:0] core_addr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  output logic [DataWidth-1:0] core_rdata_o,
  output logic                 mem_stall_o,
  output logic                 align_err_o,
  output logic                 bus_err_o,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [AddrWidth-1:0] bus_addr_o,
  output logic [3:0]           bus_be_o,
  output logic [DataWidth-1:0] bus_wdata_o,
  input  logic                 bus_ack_i,
  input  logic [DataWidth-1:0] bus_rdata_i
);

  localparam int CntW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q;
  logic [1:0]          size_q;
  logic [1:0]          lane_q;
  logic                uns_q;
  logic                bus_req_q;
  logic                bus_we_q;
  logic [AddrWidth-1:0] bus_addr_q;
  logic [3:0]          bus_be_q;
  logic [DataWidth-1:0] bus_wdata_q;
  logic [DataWidth-1:0] core_rdata_q;
  logic                bus_err_q;

  logic       req_any, req_both, misaligned, req_bad, accept, timeout;
  logic [1:0] req_size;
  logic [3:0] req_be;
  logic [DataWidth-1:0] req_wdata;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [DataWidth-1:0] load_data;
  logic unused_addr_bits;

  assign unused_addr_bits = ^core_addr_i[DataWidth-1:AddrWidth+2];

  assign req_any    = (core_read_i != 2'b00) || (core_write_i != 2'b00);
  assign req_both   = (core_read_i != 2'b00) && (core_write_i != 2'b00);
  assign req_size   = (core_read_i != 2'b00) ? core_read_i : core_write_i;
  assign misaligned = ((req_size == 2'b10) && core_addr_i[0]) ||
                      ((req_size == 2'b11) && (core_addr_i[1:0] != 2'b00));
  assign req_bad    = req_both || misaligned;
  assign accept     = (state_q == IDLE) && req_any && !req_bad && !rst_i;
  assign timeout    = (cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = core_wdata_i;
    case (req_size)
      2'b01: begin
        req_be    = 4'b1000 >> core_addr_i[1:0];
        req_wdata = {4{core_wdata_i[7:0]}};
      end
      2'b10: begin
        req_be    = core_addr_i[1] ? 4'b0011 : 4'b1100;
        req_wdata = {2{core_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_byte = bus_rdata_i[31:24];
    case (lane_q)
      2'd1:    lane_byte = bus_rdata_i[23:16];
      2'd2:    lane_byte = bus_rdata_i[15:8];
      2'd3:    lane_byte = bus_rdata_i[7:0];
      default: ;
    endcase
    lane_half = lane_q[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    case (size_q)
      2'b01:   load_data = {{24{~uns_q & lane_byte[7]}}, lane_byte};
      2'b10:   load_data = {{16{~uns_q & lane_half[15]}}, lane_half};
      default: load_data = bus_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUS;
      BUS:     if (bus_ack_i || timeout) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_stall_o = 1'b0;
    align_err_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          mem_stall_o = req_any && !req_bad;
          align_err_o = req_any && req_bad;
        end
        BUS:     mem_stall_o = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      uns_q        <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= 4'b0000;
      bus_wdata_q  <= '0;
      core_rdata_q <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      bus_err_q <= (state_q == BUS) && !bus_ack_i && timeout;
      if (accept) begin
        cnt_q       <= '0;
        size_q      <= req_size;
        lane_q      <= core_addr_i[1:0];
        uns_q       <= core_unsigned_i;
        bus_req_q   <= 1'b1;
        bus_we_q    <= (core_write_i != 2'b00);
        bus_addr_q  <= core_addr_i[AddrWidth+1:2];
        bus_be_q    <= req_be;
        bus_wdata_q <= req_wdata;
      end else if (state_q == BUS) begin
        // Ack wins over a timeout landing in the same cycle.
        if (bus_ack_i) begin
          bus_req_q    <= 1'b0;
          core_rdata_q <= bus_we_q ? '0 : load_data;
        end else if (timeout) begin
          bus_req_q    <= 1'b0;
          core_rdata_q <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end
  end

  assign core_rdata_o = core_rdata_q;
  assign bus_err_o    = bus_err_q;
  assign bus_req_o    = bus_req_q;
  assign bus_we_o     = bus_we_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_be_o     = bus_be_q;
  assign bus_wdata_o  = bus_wdata_q;

endmodule

// File: tb/tb_mem_stage_bridge.sv
// tb/tb_mem_stage_bridge.sv - self-checking bench for mem_stage_bridge
module tb_mem_stage_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  core_read, core_write;
  logic        core_unsigned;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        mem_stall, align_err, bus_err, bus_req, bus_we;
  logic [11:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_seen  = 0;
  int hs_exp   = 0;
  logic [31:0] last_rdata = 32'h0;

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        exp_align;
    logic [11:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[14];

  mem_stage_bridge #(.DataWidth(32), .AddrWidth(12), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_read_i(core_read), .core_write_i(core_write), .core_unsigned_i(core_unsigned),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_rdata_o(core_rdata),
    .mem_stall_o(mem_stall), .align_err_o(align_err), .bus_err_o(bus_err),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be),
    .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus_req && bus_ack) hs_seen++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level reference: byte counts, shifts and masks straight from the lane rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int nb, off;
    logic [1:0] sz;
    logic [31:0] mask, val;
    r = v;
    sz  = (v.rd != 2'b00) ? v.rd : v.wr;
    nb  = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
    off = int'(v.addr[1:0]);
    r.exp_align = ((v.rd != 2'b00) && (v.wr != 2'b00)) || ((off % nb) != 0);
    r.exp_addr  = v.addr[13:2];
    r.exp_be    = 4'b0;
    if (!r.exp_align) r.exp_be = 4'(((1 << nb) - 1) << (4 - nb - off));
    for (int i = 0; i < 4; i++) r.exp_wdata[8*i +: 8] = v.wdata[8*(i % nb) +: 8];
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    val  = 32'h0;
    if (!r.exp_align) val = (v.rdata >> (8 * (4 - nb - off))) & mask;
    if (!v.uns && nb < 4 && val[8*nb-1]) val = val | ~mask;
    r.exp_rdata = ((v.wr != 2'b00) || (v.delay >= TO)) ? 32'h0 : val;
    r.exp_err   = (v.delay >= TO);
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int op;
    op      = $urandom_range(0, 9);
    v.rd    = 2'($urandom_range(1, 3));
    v.wr    = 2'($urandom_range(1, 3));
    if (op < 5) v.wr = 2'b00;
    else if (op < 9) v.rd = 2'b00;
    v.uns   = 1'($urandom_range(0, 1));
    v.addr  = $urandom;
    if ($urandom_range(0, 3) != 0) v.addr[0] = 1'b0;
    if ($urandom_range(0, 2) != 0) v.addr[1] = 1'b0;
    v.wdata = $urandom;
    v.rdata = $urandom;
    v.delay = $urandom_range(0, TO + 1);
    return model(v);
  endfunction

  task automatic clear_inputs();
    core_read = 2'b00; core_write = 2'b00; core_unsigned = 1'b0;
    core_addr = 32'h0; core_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
  endtask

  task automatic run_txn(input vec_t v);
    int k, nbus;
    bit done;
    @(posedge clk); #1;
    chk("idle_bus_req", bus_req, 1'b0);
    chk("idle_bus_err", bus_err, 1'b0);
    core_read = v.rd; core_write = v.wr; core_unsigned = v.uns;
    core_addr = v.addr; core_wdata = v.wdata; bus_ack = 1'b0;
    #1;
    if (v.rd == 2'b00 && v.wr == 2'b00) begin
      chk("norq_stall", mem_stall, 1'b0);
      chk("norq_align", align_err, 1'b0);
      return;
    end
    if (v.exp_align) begin
      chk("align_err", align_err, 1'b1);
      chk("align_stall", mem_stall, 1'b0);
      @(posedge clk); #1;
      clear_inputs();
      #1;
      chk("align_no_req", bus_req, 1'b0);
      chk("align_pulse_end", align_err, 1'b0);
      chk("align_rdata_held", core_rdata, last_rdata);
      return;
    end
    chk("req_align", align_err, 1'b0);
    chk("req_stall", mem_stall, 1'b1);
    nbus = (v.delay < TO) ? v.delay + 1 : TO;
    k = 0;
    done = 0;
    while (!done && k <= TO + 2) begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      #1;
      if (mem_stall) begin
        chk("bus_req", bus_req, 1'b1);
        chk("bus_we", bus_we, v.wr != 2'b00);
        chk("bus_addr", bus_addr, v.exp_addr);
        chk("bus_be", bus_be, v.exp_be);
        if (v.wr != 2'b00) chk("bus_wdata", bus_wdata, v.exp_wdata);
        bus_ack   = (k == v.delay);
        bus_rdata = (k == v.delay) ? v.rdata : $urandom;
        k++;
      end else begin
        done = 1;
        chk("done_rdata", core_rdata, v.exp_rdata);
        chk("done_bus_err", bus_err, v.exp_err);
        chk("done_bus_req", bus_req, 1'b0);
      end
    end
    chk("done_reached", done, 1'b1);
    chk("bus_cycles", 32'(k), 32'(nbus));
    if (v.delay < TO) hs_exp++;
    last_rdata = v.exp_rdata;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    tbl[0]  = '{2'b11, 2'b00, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 1'b0, 12'h004, 4'hF, 32'h0, 32'h1234_5678, 1'b0};
    tbl[1]  = '{2'b01, 2'b00, 1'b0, 32'h0000_0003, 32'h0, 32'h0000_0080, 0, 1'b0, 12'h000, 4'h1, 32'h0, 32'hFFFF_FF80, 1'b0};
    tbl[2]  = '{2'b01, 2'b00, 1'b1, 32'h0000_0003, 32'h0, 32'h0000_0080, 0, 1'b0, 12'h000, 4'h1, 32'h0, 32'h0000_0080, 1'b0};
    tbl[3]  = '{2'b00, 2'b10, 1'b0, 32'h0000_0002, 32'h0000_ABCD, 32'h0, 1, 1'b0, 12'h000, 4'h3, 32'hABCD_ABCD, 32'h0, 1'b0};
    tbl[4]  = '{2'b10, 2'b00, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 0, 1'b1, 12'h000, 4'h0, 32'h0, 32'h0, 1'b0};
    tbl[5]  = '{2'b11, 2'b00, 1'b0, 32'h0000_0000, 32'h0, 32'h5555_AAAA, 99, 1'b0, 12'h000, 4'hF, 32'h0, 32'h0, 1'b1};
    tbl[6]  = '{2'b00, 2'b11, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 2, 1'b0, 12'h041, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0};
    tbl[7]  = '{2'b11, 2'b00, 1'b0, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 12'h041, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0};
    tbl[8]  = '{2'b10, 2'b00, 1'b0, 32'h0000_0006, 32'h0, 32'h1234_8001, 0, 1'b0, 12'h001, 4'h3, 32'h0, 32'hFFFF_8001, 1'b0};
    tbl[9]  = '{2'b01, 2'b00, 1'b1, 32'h0000_0000, 32'h0, 32'h9A00_0000, 0, 1'b0, 12'h000, 4'h8, 32'h0, 32'h0000_009A, 1'b0};
    tbl[10] = '{2'b11, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 0, 1'b1, 12'h000, 4'h0, 32'h0, 32'h0, 1'b0};
    tbl[11] = '{2'b11, 2'b00, 1'b0, 32'h0000_0002, 32'h0, 32'h0, 0, 1'b1, 12'h000, 4'h0, 32'h0, 32'h0, 1'b0};
    tbl[12] = '{2'b10, 2'b00, 1'b1, 32'h0000_0000, 32'h0, 32'h8001_7FFF, 3, 1'b0, 12'h000, 4'hC, 32'h0, 32'h0000_8001, 1'b0};
    tbl[13] = '{2'b00, 2'b01, 1'b0, 32'hFFFF_3FFD, 32'h0000_005A, 32'h0, 3, 1'b0, 12'hFFF, 4'h4, 32'h5A5A_5A5A, 32'h0, 1'b0};

    @(posedge clk); @(posedge clk); #2;
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_rdata", core_rdata, 32'h0);
    chk("rst_be", bus_be, 4'h0);
    chk("rst_addr", bus_addr, 12'h0);
    chk("rst_bus_err", bus_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_txn(tbl[i]);

    // A stray ack outside BUS must not start anything or touch load data.
    @(posedge clk); #1;
    clear_inputs();
    bus_ack = 1'b1; bus_rdata = 32'hFEED_FACE;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    #1;
    chk("stray_ack_req", bus_req, 1'b0);
    chk("stray_ack_rdata", core_rdata, last_rdata);
    chk("stray_ack_stall", mem_stall, 1'b0);

    // Reset in the middle of BUS, ack arrives in the cycle after.
    @(posedge clk); #1;
    core_read = 2'b11; core_addr = 32'h0000_0020;
    #1;
    chk("mrst_req_stall", mem_stall, 1'b1);
    @(posedge clk); #1;
    #1;
    chk("mrst_in_bus", bus_req, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    #1;
    chk("mrst_req_cleared", bus_req, 1'b0);
    chk("mrst_stall_cleared", mem_stall, 1'b0);
    chk("mrst_rdata", core_rdata, 32'h0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    #1;
    chk("mrst_late_ack_req", bus_req, 1'b0);
    chk("mrst_late_ack_rdata", core_rdata, 32'h0);
    chk("mrst_no_err", bus_err, 1'b0);
    last_rdata = 32'h0;

    for (int i = 0; i < 150; i++) run_txn(rand_vec());

    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    chk("handshake_count", 32'(hs_seen), 32'(hs_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
